// File: rtl/uart_port_ctrl.sv
// uart_port_ctrl: sequences the FT245-style parallel UART for the CPU uart slot.
// Holds one RX and one TX byte; the shared FT bus is granted round-robin between RX fetch and TX drain.
module uart_port_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int RD_PULSE    = 2,
  parameter int WR_PULSE    = 2,
  parameter int RECOVER     = 1
) (
  input  logic       clk,
  input  logic       mr,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_din,
  input  logic       cpu_rd,
  output logic [7:0] cpu_dout,
  output logic       flag_di,
  output logic       flag_do,
  output logic       err_overrun,
  input  logic       ft_rxf_n,
  input  logic       ft_txe_n,
  output logic       ft_rd_n,
  output logic       ft_wr,
  input  logic [7:0] ft_data_in,
  output logic [7:0] ft_data_out,
  output logic       ft_data_oe
);
  typedef enum logic [2:0] {IDLE, RD, WR, WR_HOLD, REC} state_t;

  localparam int CNT_MAX = (RD_PULSE > WR_PULSE) ?
                           ((RD_PULSE > RECOVER) ? RD_PULSE : RECOVER) :
                           ((WR_PULSE > RECOVER) ? WR_PULSE : RECOVER);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic RR_RX = 1'b0;
  localparam logic RR_TX = 1'b1;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               rr_last_reg, rr_last_next;
  logic [SYNC_STAGES-1:0] rxf_sync_reg, rxf_sync_next;
  logic [SYNC_STAGES-1:0] txe_sync_reg, txe_sync_next;
  logic               rxf_s, txe_s;
  logic               rx_req, tx_req, rx_capture, tx_done;
  logic [7:0]         rx_hold_reg, tx_hold_reg, ft_data_out_reg;
  logic               rx_full_reg, tx_empty_reg, err_overrun_reg;
  logic               ft_rd_n_reg, ft_wr_reg, ft_data_oe_reg;

  // Shift chain for the two asynchronous status inputs.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign rxf_sync_next[gi] = ft_rxf_n;
        assign txe_sync_next[gi] = ft_txe_n;
      end else begin : g_next
        assign rxf_sync_next[gi] = rxf_sync_reg[gi-1];
        assign txe_sync_next[gi] = txe_sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      rxf_sync_reg <= '1;
      txe_sync_reg <= '1;
    end else begin
      rxf_sync_reg <= rxf_sync_next;
      txe_sync_reg <= txe_sync_next;
    end
  end

  assign rxf_s  = rxf_sync_reg[SYNC_STAGES-1];
  assign txe_s  = txe_sync_reg[SYNC_STAGES-1];
  assign rx_req = !rx_full_reg && !rxf_s;
  assign tx_req = !tx_empty_reg && !txe_s;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rr_last_next = rr_last_reg;
    rx_capture   = 1'b0;
    tx_done      = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rx_req && (!tx_req || rr_last_reg == RR_TX)) begin
          state_next   = RD;
          rr_last_next = RR_RX;
        end else if (tx_req) begin
          state_next   = WR;
          rr_last_next = RR_TX;
        end
      end
      RD: begin
        if (cnt_reg == CNT_W'(RD_PULSE - 1)) begin
          rx_capture = 1'b1;
          cnt_next   = '0;
          state_next = REC;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      WR: begin
        if (cnt_reg == CNT_W'(WR_PULSE - 1)) begin
          cnt_next   = '0;
          state_next = WR_HOLD;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      WR_HOLD: begin
        tx_done    = 1'b1;
        cnt_next   = '0;
        state_next = REC;
      end
      REC: begin
        if (cnt_reg == CNT_W'(RECOVER - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      rr_last_reg     <= RR_TX;
      ft_rd_n_reg     <= 1'b1;
      ft_wr_reg       <= 1'b0;
      ft_data_oe_reg  <= 1'b0;
      ft_data_out_reg <= 8'h00;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      rr_last_reg    <= rr_last_next;
      ft_rd_n_reg    <= (state_next != RD);
      ft_wr_reg      <= (state_next == WR);
      ft_data_oe_reg <= (state_next == WR) || (state_next == WR_HOLD);
      if (state_next == WR) begin
        ft_data_out_reg <= tx_hold_reg;
      end
    end
  end

  // A write landing in the final WR_HOLD cycle reloads the holding register instead of overrunning.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      rx_hold_reg     <= 8'h00;
      rx_full_reg     <= 1'b0;
      tx_hold_reg     <= 8'h00;
      tx_empty_reg    <= 1'b1;
      err_overrun_reg <= 1'b0;
    end else begin
      if (rx_capture) begin
        rx_hold_reg <= ft_data_in;
        rx_full_reg <= 1'b1;
      end else if (cpu_rd && rx_full_reg) begin
        rx_full_reg <= 1'b0;
      end
      if (cpu_wr && (tx_empty_reg || tx_done)) begin
        tx_hold_reg  <= cpu_din;
        tx_empty_reg <= 1'b0;
      end else begin
        if (cpu_wr) begin
          err_overrun_reg <= 1'b1;
        end
        if (tx_done) begin
          tx_empty_reg <= 1'b1;
        end
      end
    end
  end

  assign cpu_dout    = rx_hold_reg;
  assign flag_di     = rx_full_reg;
  assign flag_do     = tx_empty_reg;
  assign err_overrun = err_overrun_reg;
  assign ft_rd_n     = ft_rd_n_reg;
  assign ft_wr       = ft_wr_reg;
  assign ft_data_out = ft_data_out_reg;
  assign ft_data_oe  = ft_data_oe_reg;
endmodule
